// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding with x0 suppression, load-use stall detection,
// per-port Wb hold registers and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [XLEN-1:0]                 ExWData,
  input  logic [REG_ADDR_W-1:0]           ExWAddr,
  input  logic                            ExWEn,
  input  logic                            ExWReady,
  input  logic [XLEN-1:0]                 MemWData,
  input  logic [REG_ADDR_W-1:0]           MemWAddr,
  input  logic                            MemWEn,
  input  logic                            MemWReady,
  input  logic [XLEN-1:0]                 WbWData,
  input  logic [REG_ADDR_W-1:0]           WbWAddr,
  input  logic                            WbWEn,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] RsAddrIn,
  input  logic [NUM_RD_PORTS-1:0]         RsEnIn,
  input  logic [NUM_RD_PORTS*XLEN-1:0]    RfDataIn,
  input  logic                            IdValidIn,
  input  logic                            IdStallIn,
  input  logic                            FlushIn,
  input  logic                            CntClrIn,
  output logic [NUM_RD_PORTS*XLEN-1:0]    RsDataOut,
  output logic [NUM_RD_PORTS*3-1:0]       FwdSrcOut,
  output logic                            HazardStallOut,
  output logic [CNT_W-1:0]                StallCountOut
);

  localparam int unsigned SRC_W = 3;
  localparam logic [SRC_W-1:0] SRC_RF   = 3'd0;
  localparam logic [SRC_W-1:0] SRC_HOLD = 3'd1;
  localparam logic [SRC_W-1:0] SRC_WB   = 3'd2;
  localparam logic [SRC_W-1:0] SRC_MEM  = 3'd3;
  localparam logic [SRC_W-1:0] SRC_EX   = 3'd4;

  logic [NUM_RD_PORTS-1:0] hold_valid_q;
  logic [XLEN-1:0]         hold_data_q [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] hit_wb;
  logic [NUM_RD_PORTS-1:0] port_stall;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    id_fire;

  // Per-port match detection and priority source selection
  for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_port
    logic [REG_ADDR_W-1:0] rs_addr;
    logic                  rs_live;
    logic                  hit_ex, hit_mem, hit_hold;
    logic [XLEN-1:0]       data_c;
    logic [SRC_W-1:0]      src_c;

    assign rs_addr   = RsAddrIn[g*REG_ADDR_W +: REG_ADDR_W];
    assign rs_live   = RsEnIn[g] && (rs_addr != '0);
    assign hit_ex    = rs_live && ExWEn  && (ExWAddr  == rs_addr);
    assign hit_mem   = rs_live && MemWEn && (MemWAddr == rs_addr);
    assign hit_wb[g] = rs_live && WbWEn  && (WbWAddr  == rs_addr);
    assign hit_hold  = rs_live && hold_valid_q[g];

    always_comb begin
      src_c  = SRC_RF;
      data_c = (RsEnIn[g] && (rs_addr == '0)) ? '0 : RfDataIn[g*XLEN +: XLEN];
      if (hit_ex) begin
        src_c  = SRC_EX;
        data_c = ExWData;
      end else if (hit_mem) begin
        src_c  = SRC_MEM;
        data_c = MemWData;
      end else if (hit_wb[g]) begin
        src_c  = SRC_WB;
        data_c = WbWData;
      end else if (hit_hold) begin
        src_c  = SRC_HOLD;
        data_c = hold_data_q[g];
      end
    end

    // A not-ready producer stalls; lower stages never substitute for it
    assign port_stall[g] = ((src_c == SRC_EX)  && !ExWReady) ||
                           ((src_c == SRC_MEM) && !MemWReady);

    assign RsDataOut[g*XLEN +: XLEN]   = data_c;
    assign FwdSrcOut[g*SRC_W +: SRC_W] = src_c;
  end

  assign HazardStallOut = IdValidIn && (|port_stall);
  assign id_fire        = IdValidIn && !IdStallIn && !HazardStallOut;

  // Keep Wb results that retire while the consumer is still waiting in ID
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_RD_PORTS; i++) hold_data_q[i] <= '0;
    end else if (FlushIn || id_fire) begin
      hold_valid_q <= '0;
    end else if (IdValidIn) begin
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
        if (hit_wb[i]) begin
          hold_valid_q[i] <= 1'b1;
          hold_data_q[i]  <= WbWData;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (CntClrIn) cnt_d = '0;
    else if (HazardStallOut && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign StallCountOut = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed scenarios plus random traffic
// checked against a priority-list reference model.
module tb_fwd_hazard_unit;

  localparam int N  = 2;
  localparam int XL = 64;
  localparam int AW = 5;
  localparam int CW = 4;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [XL-1:0]   ExWData, MemWData, WbWData;
  logic [AW-1:0]   ExWAddr, MemWAddr, WbWAddr;
  logic            ExWEn, ExWReady, MemWEn, MemWReady, WbWEn;
  logic [N*AW-1:0] RsAddrIn;
  logic [N-1:0]    RsEnIn;
  logic [N*XL-1:0] RfDataIn;
  logic            IdValidIn, IdStallIn, FlushIn, CntClrIn;
  logic [N*XL-1:0] RsDataOut;
  logic [N*3-1:0]  FwdSrcOut;
  logic            HazardStallOut;
  logic [CW-1:0]   StallCountOut;

  fwd_hazard_unit #(.NUM_RD_PORTS(N), .XLEN(XL), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .ExWData(ExWData), .ExWAddr(ExWAddr), .ExWEn(ExWEn), .ExWReady(ExWReady),
    .MemWData(MemWData), .MemWAddr(MemWAddr), .MemWEn(MemWEn), .MemWReady(MemWReady),
    .WbWData(WbWData), .WbWAddr(WbWAddr), .WbWEn(WbWEn),
    .RsAddrIn(RsAddrIn), .RsEnIn(RsEnIn), .RfDataIn(RfDataIn),
    .IdValidIn(IdValidIn), .IdStallIn(IdStallIn), .FlushIn(FlushIn), .CntClrIn(CntClrIn),
    .RsDataOut(RsDataOut), .FwdSrcOut(FwdSrcOut),
    .HazardStallOut(HazardStallOut), .StallCountOut(StallCountOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N*XL-1:0] data;
    logic [N*3-1:0]  src;
    logic            stall;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic          m_hv [N];
  logic [XL-1:0] m_hd [N];
  int            m_cnt;

  function automatic void model_reset();
    for (int p = 0; p < N; p++) begin
      m_hv[p] = 1'b0;
      m_hd[p] = '0;
    end
    m_cnt = 0;
  endfunction

  // Candidates listed highest priority first; scan lowest first so the highest hit wins last
  function automatic void model_port(input int p, output logic [XL-1:0] d, output int s);
    logic [AW-1:0] a;
    logic          live;
    logic          cv [4];
    logic [XL-1:0] cd [4];
    int            cs [4];
    a    = RsAddrIn[p*AW +: AW];
    live = RsEnIn[p] && (a != 0);
    cv[0] = live && ExWEn  && (ExWAddr  == a); cd[0] = ExWData;  cs[0] = 4;
    cv[1] = live && MemWEn && (MemWAddr == a); cd[1] = MemWData; cs[1] = 3;
    cv[2] = live && WbWEn  && (WbWAddr  == a); cd[2] = WbWData;  cs[2] = 2;
    cv[3] = live && m_hv[p];                   cd[3] = m_hd[p];  cs[3] = 1;
    d = (RsEnIn[p] && a == 0) ? '0 : RfDataIn[p*XL +: XL];
    s = 0;
    for (int k = 3; k >= 0; k--) if (cv[k]) begin d = cd[k]; s = cs[k]; end
  endfunction

  function automatic logic model_stall();
    logic [XL-1:0] d;
    int            s;
    logic          st;
    st = 1'b0;
    for (int p = 0; p < N; p++) begin
      model_port(p, d, s);
      if ((s == 4 && !ExWReady) || (s == 3 && !MemWReady)) st = 1'b1;
    end
    return IdValidIn && st;
  endfunction

  // Advance model state with the inputs that were present at this clock edge
  function automatic void model_update();
    logic st, fire;
    if (!Rst) begin
      model_reset();
      return;
    end
    st   = model_stall();
    fire = IdValidIn && !IdStallIn && !st;
    if (CntClrIn)  m_cnt = 0;
    else if (st)   m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    if (FlushIn || fire) begin
      for (int p = 0; p < N; p++) m_hv[p] = 1'b0;
    end else if (IdValidIn) begin
      for (int p = 0; p < N; p++) begin
        if (RsEnIn[p] && RsAddrIn[p*AW +: AW] != 0 && WbWEn && WbWAddr == RsAddrIn[p*AW +: AW]) begin
          m_hv[p] = 1'b1;
          m_hd[p] = WbWData;
        end
      end
    end
  endfunction

  task automatic check();
    exp_t e;
    logic [XL-1:0] d;
    int            s;
    for (int p = 0; p < N; p++) begin
      model_port(p, d, s);
      e.data[p*XL +: XL] = d;
      e.src[p*3 +: 3]    = 3'(s);
    end
    e.stall = model_stall();
    e.cnt   = CW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic clear_in();
    ExWData = '0; ExWAddr = '0; ExWEn = 0; ExWReady = 1;
    MemWData = '0; MemWAddr = '0; MemWEn = 0; MemWReady = 1;
    WbWData = '0; WbWAddr = '0; WbWEn = 0;
    RsAddrIn = '0; RsEnIn = '0; RfDataIn = '0;
    IdValidIn = 0; IdStallIn = 0; FlushIn = 0; CntClrIn = 0;
  endtask

  task automatic set_loaduse();
    IdValidIn = 1; RsEnIn = 2'b01; RsAddrIn[AW-1:0] = 5'd3;
    ExWAddr = 5'd3; ExWEn = 1; ExWReady = 0;
    MemWAddr = 5'd3; MemWEn = 1; MemWReady = 1; MemWData = 64'h7;
  endtask

  // Monitor: outputs are live every cycle, compare one expectation per falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < N; p++) begin
          n_tests++;
          if (RsDataOut[p*XL +: XL] !== e.data[p*XL +: XL]) begin
            n_fail++;
            $display("FAIL rsdata port%0d got %h exp %h @%0t", p, RsDataOut[p*XL +: XL], e.data[p*XL +: XL], $time);
          end
          n_tests++;
          if (FwdSrcOut[p*3 +: 3] !== e.src[p*3 +: 3]) begin
            n_fail++;
            $display("FAIL fwdsrc port%0d got %0d exp %0d @%0t", p, FwdSrcOut[p*3 +: 3], e.src[p*3 +: 3], $time);
          end
        end
        n_tests++;
        if (HazardStallOut !== e.stall) begin
          n_fail++;
          $display("FAIL stall got %b exp %b @%0t", HazardStallOut, e.stall, $time);
        end
        n_tests++;
        if (StallCountOut !== e.cnt) begin
          n_fail++;
          $display("FAIL count got %0d exp %0d @%0t", StallCountOut, e.cnt, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    clear_in();
    Rst = 0;
    repeat (2) @(posedge Clk);
    #1;
    check();
    cyc(); Rst = 1; check();

    // Ex beats Mem on same rd
    cyc(); clear_in(); RsEnIn = 2'b01; RsAddrIn[AW-1:0] = 5'd5;
    ExWAddr = 5'd5; ExWEn = 1; ExWData = 64'hAA;
    MemWAddr = 5'd5; MemWEn = 1; MemWData = 64'hBB; check();

    // x0 read returns zero
    cyc(); clear_in(); RsEnIn = 2'b10; RsAddrIn[2*AW-1:AW] = 5'd0;
    ExWAddr = 5'd0; ExWEn = 1; ExWData = 64'h11; RfDataIn[2*XL-1:XL] = 64'h99; check();

    // Load-use stall for 3 cycles
    cyc(); clear_in(); CntClrIn = 1; check();
    cyc(); CntClrIn = 0; set_loaduse(); check();
    repeat (3) begin cyc(); check(); end

    // Hold capture while stalled, then release
    cyc(); clear_in(); IdValidIn = 1; IdStallIn = 1; RsEnIn = 2'b01; RsAddrIn[AW-1:0] = 5'd7;
    WbWAddr = 5'd7; WbWEn = 1; WbWData = 64'h1234; check();
    cyc(); WbWEn = 0; check();
    cyc(); IdStallIn = 0; check();
    cyc(); check();

    // Flush wins over capture
    cyc(); IdStallIn = 1; WbWEn = 1; WbWData = 64'h5555; FlushIn = 1; check();
    cyc(); FlushIn = 0; WbWEn = 0; check();

    // Asynchronous reset drops hold and counter
    cyc(); WbWEn = 1; WbWData = 64'hABCD; check();
    cyc(); WbWEn = 0; check();
    cyc(); Rst = 0; model_reset(); #1; check();
    cyc(); Rst = 1; check();

    // Counter saturation and clear-during-stall
    cyc(); clear_in(); set_loaduse(); check();
    repeat (20) begin cyc(); check(); end
    cyc(); CntClrIn = 1; check();
    cyc(); check();
    cyc(); CntClrIn = 0; check();

    // Random traffic
    repeat (400) begin
      cyc();
      ExWData  = {$urandom, $urandom}; ExWAddr  = 5'($urandom_range(0, 3));
      ExWEn    = 1'($urandom); ExWReady = ($urandom_range(0, 9) < 7);
      MemWData = {$urandom, $urandom}; MemWAddr = 5'($urandom_range(0, 3));
      MemWEn   = 1'($urandom); MemWReady = ($urandom_range(0, 9) < 8);
      WbWData  = {$urandom, $urandom}; WbWAddr  = 5'($urandom_range(0, 3));
      WbWEn    = 1'($urandom);
      for (int p = 0; p < N; p++) begin
        RsAddrIn[p*AW +: AW] = 5'($urandom_range(0, 3));
        RfDataIn[p*XL +: XL] = {$urandom, $urandom};
      end
      RsEnIn    = 2'($urandom);
      IdValidIn = ($urandom_range(0, 19) < 17);
      IdStallIn = ($urandom_range(0, 9) < 3);
      FlushIn   = ($urandom_range(0, 19) == 0);
      CntClrIn  = ($urandom_range(0, 39) == 0);
      check();
    end

    repeat (3) @(posedge Clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
